// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder that sums two 4*NIBBLES-bit operands one nibble per clock through a 4-bit chain.
// Optional signed-overflow output is enabled with the NSA_OVERFLOW_EN macro.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  input  logic                 i_cin,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [4*NIBBLES-1:0] o_sum,
  output logic                 o_cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic                 o_ovf
`endif
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] KLast = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic            r_cout;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [KW+1:0]   w_base;
  logic [3:0]      w_an;
  logic [3:0]      w_bn;
  logic [3:0]      w_nsum;
  logic            w_carry;
`ifdef NSA_OVERFLOW_EN
  logic            r_ovf;
  logic            w_cmsb;
`endif

  assign w_base = {r_k, 2'b00};
  assign w_an   = r_a[w_base +: 4];
  assign w_bn   = r_b[w_base +: 4];

  // 4-bit ripple chain; w_carry walks from the registered carry to the nibble carry-out.
  always_comb begin
    w_nsum  = 4'b0;
    w_carry = r_carry;
`ifdef NSA_OVERFLOW_EN
    w_cmsb  = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
`ifdef NSA_OVERFLOW_EN
      if (i == 3) w_cmsb = w_carry;
`endif
      w_nsum[i] = w_an[i] ^ w_bn[i] ^ w_carry;
      w_carry   = (w_an[i] & w_bn[i]) | (w_carry & (w_an[i] ^ w_bn[i]));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_k         <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_a        <= i_a;
            r_b        <= i_b;
            r_carry    <= i_cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StRun;
          end
        end
        StRun: begin
          r_sum[w_base +: 4] <= w_nsum;
          r_carry            <= w_carry;
          if (r_k == KLast) begin
            r_cout      <= w_carry;
`ifdef NSA_OVERFLOW_EN
            r_ovf       <= w_cmsb ^ w_carry;
`endif
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        StDone: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
`ifdef NSA_OVERFLOW_EN
  assign o_ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 4-nibble and a 1-nibble instance share one clock.
// Overflow checks are compiled in when NSA_OVERFLOW_EN is defined.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [15:0] a, b, sum;
  logic        u1_in_valid, u1_in_ready, u1_out_valid, u1_out_ready, u1_cin, u1_cout;
  logic [3:0]  u1_a, u1_b, u1_sum;
`ifdef NSA_OVERFLOW_EN
  logic        ovf, u1_ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_cin(cin), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_sum(sum), .o_cout(cout)
`ifdef NSA_OVERFLOW_EN
    , .o_ovf(ovf)
`endif
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(u1_in_valid), .o_in_ready(u1_in_ready),
    .i_a(u1_a), .i_b(u1_b), .i_cin(u1_cin), .o_out_valid(u1_out_valid),
    .i_out_ready(u1_out_ready), .o_sum(u1_sum), .o_cout(u1_cout)
`ifdef NSA_OVERFLOW_EN
    , .o_ovf(u1_ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepts one operand set on the 4-nibble instance and waits (bounded) for out_valid.
  // Returns at the negedge where out_valid is first seen high.
  task automatic start_add4(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                            input string tag);
    int n;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = ~tcin;
    check({tag, "_ready_low"}, in_ready, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 4);
  endtask

  task automatic add4(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                      input logic [15:0] esum, input logic ecout, input logic eovf,
                      input string tag);
    start_add4(ta, tb, tcin, tag);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
`ifdef NSA_OVERFLOW_EN
    check({tag, "_ovf"}, ovf, eovf);
`else
    if (eovf === 1'bx) $display("unexpected ovf expectation in %s", tag);
`endif
    check({tag, "_done_ready"}, in_ready, 1'b0);
    @(negedge clk);
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    u1_in_valid = 1'b0; u1_out_ready = 1'b1; u1_a = '0; u1_b = '0; u1_cin = 1'b0;

    rst = 1'b1;
    // A transfer offered while in reset must be ignored.
    in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_sum", sum, 16'h0000);
    check("reset_cout", cout, 1'b0);
`ifdef NSA_OVERFLOW_EN
    check("reset_ovf", ovf, 1'b0);
`endif

    add4(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "basic");
    add4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    add4(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "posovf");
    add4(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "cin_only");
    add4(16'hA5C3, 16'h5A3C, 1'b1, 16'h0000, 1'b1, 1'b0, "full_ripple");

    // Backpressure: result must hold for 10 cycles with out_ready low.
    out_ready = 1'b0;
    start_add4(16'h8000, 16'h8000, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_sum", sum, 16'h0000);
      check("bp_cout", cout, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
`ifdef NSA_OVERFLOW_EN
      check("bp_ovf", ovf, 1'b1);
`endif
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_valid", out_valid, 1'b0);

    // Reset mid-operation at k=2, checked before any clock edge.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, 16'h0000);
    check("midrst_cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    add4(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst");

    // Single-nibble instance; in_valid held during RUN/DONE must not be accepted.
    @(negedge clk);
    u1_a = 4'hF; u1_b = 4'h1; u1_cin = 1'b1; u1_in_valid = 1'b1; u1_out_ready = 1'b0;
    @(negedge clk);
    check("n1_run_ready", u1_in_ready, 1'b0);
    check("n1_run_valid", u1_out_valid, 1'b0);
    u1_a = 4'h3; u1_b = 4'h3; u1_cin = 1'b0;
    @(negedge clk);
    check("n1_valid", u1_out_valid, 1'b1);
    check("n1_sum", u1_sum, 4'h1);
    check("n1_cout", u1_cout, 1'b1);
`ifdef NSA_OVERFLOW_EN
    check("n1_ovf", u1_ovf, 1'b0);
`endif
    @(negedge clk);
    check("n1_hold_sum", u1_sum, 4'h1);
    check("n1_hold_ready", u1_in_ready, 1'b0);
    u1_in_valid = 1'b0; u1_out_ready = 1'b1;
    @(negedge clk);
    check("n1_idle_ready", u1_in_ready, 1'b1);
    check("n1_idle_valid", u1_out_valid, 1'b0);
    @(negedge clk);
    check("n1_no_stray", u1_in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
